// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter
// 5..DBIT_MAX data bits, none/even/odd/mark parity, 1/1.5/2 stop, break
`timescale 1ns/1ps
module uart_tx_cfg #(
   parameter int DBIT_MAX = 9,
   parameter int OVS      = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                s_tick,
   input  logic [3:0]          cfg_dbits,
   input  logic [1:0]          cfg_parity,
   input  logic [1:0]          cfg_stop,
   input  logic                tx_break,
   input  logic                tx_valid,
   input  logic [DBIT_MAX-1:0] tx_data,
   output logic                tx_ready,
   output logic                tx_busy,
   output logic                tx_done_tick,
   output logic                tx
);

   localparam int TW = $clog2(2 * OVS);
   localparam logic [TW-1:0] BIT_LAST = TW'(OVS - 1);
   localparam logic [TW-1:0] S15_LAST = TW'(3 * OVS / 2 - 1);
   localparam logic [TW-1:0] S2_LAST  = TW'(2 * OVS - 1);
   localparam logic [3:0]    DMAX     = 4'(DBIT_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t              state_q;
   logic [TW-1:0]       tick_q;
   logic [3:0]          bit_q;
   logic [3:0]          dbits_q;
   logic [DBIT_MAX-1:0] shift_q;
   logic [1:0]          stop_q;
   logic                pen_q;
   logic                par_q;
   logic                tx_q;
   logic                done_q;

   logic [3:0]          dbits_d;
   logic [DBIT_MAX-1:0] data_d;
   logic                par_d;
   logic [TW-1:0]       stop_last;
   logic                line_d;

   // clamp requested data length into 5..DBIT_MAX
   always_comb begin
      dbits_d = cfg_dbits;
      if (cfg_dbits < 4'd5) begin
         dbits_d = 4'd5;
      end else if (cfg_dbits > DMAX) begin
         dbits_d = DMAX;
      end
   end

   // drop data bits beyond the active length
   always_comb begin
      data_d = '0;
      for (int i = 0; i < DBIT_MAX; i++) begin
         if (4'(i) < dbits_d) begin
            data_d[i] = tx_data[i];
         end
      end
   end

   // parity bit for the word being accepted
   always_comb begin
      unique case (cfg_parity)
         2'b01:   par_d = ^data_d;
         2'b10:   par_d = ~^data_d;
         default: par_d = 1'b1;
      endcase
   end

   // last tick index of the latched stop length
   always_comb begin
      unique case (stop_q)
         2'b00:   stop_last = BIT_LAST;
         2'b01:   stop_last = S15_LAST;
         default: stop_last = S2_LAST;
      endcase
   end

   // line level for the current state, registered into tx_q
   always_comb begin
      unique case (state_q)
         S_START,
         S_BREAK:  line_d = 1'b0;
         S_DATA:   line_d = shift_q[0];
         S_PARITY: line_d = par_q;
         default:  line_d = 1'b1;
      endcase
   end

   // frame sequencer with registered line and done pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         dbits_q <= '0;
         shift_q <= '0;
         stop_q  <= '0;
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         tx_q   <= line_d;
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (tx_break) begin
                  state_q <= S_BREAK;
               end else if (tx_valid) begin
                  shift_q <= data_d;
                  dbits_q <= dbits_d;
                  pen_q   <= (cfg_parity != 2'b00);
                  par_q   <= par_d;
                  stop_q  <= cfg_stop;
                  tick_q  <= '0;
                  state_q <= S_START;
               end
            end
            S_BREAK: begin
               if (!tx_break) begin
                  state_q <= S_IDLE;
               end
            end
            S_START: begin
               if (s_tick) begin
                  if (tick_q == BIT_LAST) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     state_q <= S_DATA;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (s_tick) begin
                  if (tick_q == BIT_LAST) begin
                     tick_q  <= '0;
                     shift_q <= shift_q >> 1;
                     if (bit_q == dbits_q - 4'd1) begin
                        state_q <= pen_q ? S_PARITY : S_STOP;
                     end else begin
                        bit_q <= bit_q + 4'd1;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (s_tick) begin
                  if (tick_q == BIT_LAST) begin
                     tick_q  <= '0;
                     state_q <= S_STOP;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (s_tick) begin
                  if (tick_q == stop_last) begin
                     tick_q  <= '0;
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx           = tx_q;
   assign tx_done_tick = done_q;
   assign tx_busy      = (state_q != S_IDLE);
   assign tx_ready     = (state_q == S_IDLE) && !tx_break;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg
// frames decoded by mid-bit sampling of tx on the falling clock edge
`timescale 1ns/1ps
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       s_tick = 1'b0;
   logic [3:0] cfg_dbits = 4'd8;
   logic [1:0] cfg_parity = 2'b00;
   logic [1:0] cfg_stop = 2'b00;
   logic       tx_break = 1'b0;
   logic       tx_valid = 1'b0;
   logic [8:0] tx_data = '0;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done_tick;
   logic       tx;

   int errors = 0;
   int checks = 0;
   int div = 1;
   int div_cnt = 0;
   bit tick_en = 1'b1;
   int done_cnt = 0;
   int acc_cnt = 0;

   logic [8:0] rx_d;
   logic       rx_p;
   logic       rx_start;
   logic       rx_stop_ok;
   logic       rx_rdy;
   int         rx_done_idx;
   int         rx_wait;

   int d0;
   int a0;

   uart_tx_cfg #(.DBIT_MAX(9), .OVS(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_tick       (s_tick),
      .cfg_dbits    (cfg_dbits),
      .cfg_parity   (cfg_parity),
      .cfg_stop     (cfg_stop),
      .tx_break     (tx_break),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick),
      .tx           (tx)
   );

   always #5 clk = ~clk;

   // baud strobe: one clk high every div clks
   always @(negedge clk) begin
      if (div_cnt >= div - 1) div_cnt = 0;
      else div_cnt++;
      s_tick = tick_en && (div_cnt == 0);
   end

   // count done pulses and accepted words
   always @(posedge clk) begin
      if (tx_done_tick === 1'b1) done_cnt++;
      if (tx_ready === 1'b1 && tx_valid === 1'b1) acc_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [8:0] d, input logic [3:0] nb,
                       input logic [1:0] par, input logic [1:0] st);
      @(negedge clk);
      tx_data = d;
      cfg_dbits = nb;
      cfg_parity = par;
      cfg_stop = st;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic rx_frame(input int n, input bit pen, input int dv);
      int bp;
      int idx;
      int lim;
      int sidx;
      bp = 16 * dv;
      rx_d = '0;
      rx_p = 1'b0;
      rx_start = 1'b1;
      rx_stop_ok = 1'b1;
      rx_rdy = 1'b0;
      rx_done_idx = -1;
      rx_wait = 0;
      @(negedge clk);
      while (tx !== 1'b0 && rx_wait < 4000) begin
         @(negedge clk);
         rx_wait++;
      end
      sidx = bp * (1 + n + int'(pen));
      lim = sidx + 2 * bp + 8;
      idx = 0;
      while (rx_done_idx < 0 && idx <= lim) begin
         if (idx == bp / 2) rx_start = tx;
         for (int k = 0; k < n; k++)
            if (idx == bp * (k + 1) + bp / 2) rx_d[k] = tx;
         if (pen && idx == bp * (n + 1) + bp / 2) rx_p = tx;
         if (idx > sidx + 1 && tx !== 1'b1) rx_stop_ok = 1'b0;
         if (tx_done_tick === 1'b1) begin
            rx_done_idx = idx;
            rx_rdy = tx_ready;
         end else begin
            @(negedge clk);
            idx++;
         end
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done_tick, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // 8N1 0x55
      d0 = done_cnt;
      send(9'h055, 4'd8, 2'b00, 2'b00);
      chk("8n1_busy", tx_busy, 1);
      rx_frame(8, 1'b0, 1);
      chk("8n1_lat", rx_wait, 1);
      chk("8n1_start", rx_start, 0);
      chk("8n1_data", rx_d, 9'h055);
      chk("8n1_stop", rx_stop_ok, 1);
      chk("8n1_len", rx_done_idx, 159);
      chk("8n1_rdy", rx_rdy, 1);
      repeat (3) @(negedge clk);
      chk("8n1_ndone", done_cnt, d0 + 1);
      chk("8n1_idle", tx, 1);

      // 7E1 0x41 then 7O1
      send(9'h041, 4'd7, 2'b01, 2'b00);
      rx_frame(7, 1'b1, 1);
      chk("7e1_data", rx_d, 9'h041);
      chk("7e1_par", rx_p, 0);
      chk("7e1_len", rx_done_idx, 159);
      repeat (3) @(negedge clk);
      send(9'h041, 4'd7, 2'b10, 2'b00);
      rx_frame(7, 1'b1, 1);
      chk("7o1_data", rx_d, 9'h041);
      chk("7o1_par", rx_p, 1);
      repeat (3) @(negedge clk);

      // 5O2 0x3F
      send(9'h03F, 4'd5, 2'b10, 2'b10);
      rx_frame(5, 1'b1, 1);
      chk("5o2_data", rx_d, 9'h01F);
      chk("5o2_par", rx_p, 0);
      chk("5o2_stop", rx_stop_ok, 1);
      chk("5o2_len", rx_done_idx, 143);
      repeat (3) @(negedge clk);

      // dbits 12 clamps to 9, 1.5 stop
      send(9'h1AB, 4'd12, 2'b00, 2'b01);
      rx_frame(9, 1'b0, 1);
      chk("clamp9_data", rx_d, 9'h1AB);
      chk("clamp9_len", rx_done_idx, 183);
      repeat (3) @(negedge clk);

      // dbits 2 clamps to 5
      send(9'h1F5, 4'd2, 2'b00, 2'b00);
      rx_frame(5, 1'b0, 1);
      chk("clamp5_data", rx_d, 9'h015);
      chk("clamp5_len", rx_done_idx, 111);
      repeat (3) @(negedge clk);

      // back-to-back with config change mid-frame
      a0 = acc_cnt;
      @(negedge clk);
      tx_data = 9'h0A5;
      cfg_dbits = 4'd8;
      cfg_parity = 2'b01;
      cfg_stop = 2'b00;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_data = 9'h03C;
      cfg_parity = 2'b10;
      rx_frame(8, 1'b1, 1);
      chk("b2b1_data", rx_d, 9'h0A5);
      chk("b2b1_par", rx_p, 0);
      chk("b2b1_len", rx_done_idx, 175);
      chk("b2b1_rdy", rx_rdy, 1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      chk("b2b_acc", acc_cnt, a0 + 2);
      rx_frame(8, 1'b1, 1);
      chk("b2b_gap", rx_wait, 1);
      chk("b2b2_data", rx_d, 9'h03C);
      chk("b2b2_par", rx_p, 1);
      chk("b2b2_len", rx_done_idx, 175);
      repeat (3) @(negedge clk);

      // break held in idle overrides tx_valid
      a0 = acc_cnt;
      d0 = done_cnt;
      @(negedge clk);
      tx_data = 9'h081;
      cfg_dbits = 4'd8;
      cfg_parity = 2'b00;
      cfg_stop = 2'b00;
      tx_valid = 1'b1;
      tx_break = 1'b1;
      repeat (100) @(negedge clk);
      chk("brk_tx", tx, 0);
      chk("brk_ready", tx_ready, 0);
      chk("brk_busy", tx_busy, 1);
      chk("brk_acc", acc_cnt, a0);
      chk("brk_done", done_cnt, d0);
      tx_break = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      chk("brk_rel_acc", acc_cnt, a0 + 1);
      rx_frame(8, 1'b0, 1);
      chk("brk_rel_lat", rx_wait, 1);
      chk("brk_rel_data", rx_d, 9'h081);
      chk("brk_rel_len", rx_done_idx, 159);
      repeat (3) @(negedge clk);

      // reset mid-frame
      d0 = done_cnt;
      send(9'h0F0, 4'd8, 2'b00, 2'b00);
      repeat (40) @(negedge clk);
      chk("rstmid_pre", tx, 0);
      reset_n = 1'b0;
      #1;
      chk("rstmid_tx", tx, 1);
      chk("rstmid_busy", tx_busy, 0);
      chk("rstmid_done", tx_done_tick, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("rstmid_ndone", done_cnt, d0);
      chk("rstmid_idle", tx, 1);

      // strobe every other clk: frame stretches to about 2x
      div = 2;
      repeat (4) @(negedge clk);
      send(9'h00A, 4'd5, 2'b00, 2'b00);
      rx_frame(5, 1'b0, 2);
      chk("div2_data", rx_d, 9'h00A);
      chk("div2_len", (rx_done_idx >= 221 && rx_done_idx <= 224), 1);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter that serialises one frame per accepted word. It replaces the fixed 8N1 transmitter and adds selectable data length, parity, stop-bit length, a ready/valid input handshake and line-break generation. It sits between the TX holding logic (FIFO or CPU register) and the pad, and is clocked by clk with a shared baud-rate s_tick strobe at OVS ticks per bit.

## Interface
- DBIT_MAX, 9: widest data field supported; legal range 5..9.
- OVS, 16: s_ticks per bit; must be even and at least 4.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- s_tick  in  1  one-clk baud oversample strobe.
- cfg_dbits  in  4  data bits per frame. Values below 5 clamp to 5; values above DBIT_MAX clamp to DBIT_MAX.
- cfg_parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 mark (constant 1).
- cfg_stop  in  2  stop length: 00 one bit, 01 1.5 bits, 10 or 11 two bits.
- tx_break  in  1  request to hold the line low (break).
- tx_valid  in  1  tx_data is valid.
- tx_data  in  DBIT_MAX  word to send, LSB first. Bits at index cfg_dbits and above are ignored.
- tx_ready  out  1  word accepted on this edge if tx_valid is also high.
- tx_busy  out  1  a frame or a break is in progress.
- tx_done_tick  out  1  one-clk pulse at end of frame.
- tx  out  1  serial line. Idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE
  - tx_ready = 1 when tx_break = 0.
  - If tx_valid is high, the block latches tx_data, the clamped cfg_dbits, cfg_parity and cfg_stop, clears the tick counter and goes to START.
  - Config changes during a frame have no effect on that frame.
- IDLE with tx_break = 1: go to BREAK (break takes priority over tx_valid). tx_ready = 0.
- BREAK: tx = 0. Return to IDLE on the first clk where tx_break = 0. tx_done_tick is not pulsed.
- START: tx = 0 for OVS s_ticks, then DATA with the bit index set to 0.
- DATA
  - tx = shift[0] for OVS s_ticks per bit, then shift right.
  - After bit n−1 (n = latched dbits): go to PARITY if parity is not 00, otherwise go to STOP.
- PARITY: tx = the parity bit for OVS s_ticks.
  - Even: XOR of the n data bits.
  - Odd: the inverse of that XOR.
  - Mark: 1.
- STOP: tx = 1 for OVS, 3·OVS/2 or 2·OVS s_ticks, according to the latched cfg_stop. Then go to IDLE and pulse tx_done_tick.
- Tick counter
  - Width is clog2(2·OVS).
  - Increments only on s_tick and resets to 0 on every state change.
  - s_tick is ignored in IDLE and BREAK.
- Frame length in s_ticks = OVS·(1 + n + p) + stop_ticks, where p = 1 if parity is enabled, else 0.
- tx_busy = 1 in every state except IDLE.
- Out-of-range cfg_dbits is clamped, never rejected.

## Timing
- Reset values:
  - tx = 1, tx_ready = 1, tx_busy = 0, tx_done_tick = 0.
  - State IDLE; counters and shift register 0.
- Reset asserted mid-frame: tx returns high asynchronously and the frame is abandoned with no done pulse.
- tx is registered.
  - Acceptance at edge E: tx falls at E+1.
  - Each bit boundary appears on tx one clk after the edge that sampled the terminating s_tick.
- tx_done_tick is registered. It is high for exactly the one clk after the final stop s_tick edge, and is coincident with tx_ready = 1.
- Back-to-back: if tx_valid is held high, the next word is accepted in that same IDLE cycle. The idle gap between frames is one clk.
- tx_break asserted mid-frame is ignored until the frame completes. It is honoured in IDLE and overrides a pending tx_valid.
- s_tick on the same edge as acceptance is not counted.

## Test plan
- 8N1, data 0x55, OVS = 16
  - Stimulus: one word accepted.
  - Required response: tx = 0,1,0,1,0,1,0,1,0 then 1 (stop), each bit exactly 16 s_ticks. tx_done_tick pulses once and tx_ready returns to 1.
- 7E1, data 0x41
  - Stimulus: one word accepted.
  - Required response: data bits 1,0,0,0,0,0,1, then parity 0, then 16-tick stop. Repeating with odd parity (10) gives parity 1.
- 5O2, data 0x3F
  - Stimulus: one word accepted.
  - Required response: only 5 bits sent (1,1,1,1,1), bit 5 ignored. Odd parity 0, stop high for 32 ticks.
- 1.5 stop and clamping
  - Stimulus: cfg_stop = 01, cfg_dbits = 12.
  - Required response: 9 data bits sent (clamped) and stop lasts 24 ticks.
  - Stimulus: cfg_dbits = 2.
  - Required response: 5 data bits sent.
- Back-to-back and config change
  - Stimulus: tx_valid held for 0xA5 then 0x3C; cfg_parity changes mid-frame.
  - Required response: first frame uses the config latched at its accept. The second accept happens in the done cycle. Gap is 1 clk.
- Break and reset
  - Stimulus: tx_break held for 100 clk in IDLE with tx_valid high.
  - Required response: tx = 0, tx_ready = 0, no accept. Accept occurs after release.
  - Stimulus: reset_n pulsed low during DATA.
  - Required response: tx = 1 immediately, tx_busy = 0, no tx_done_tick.
